// File: rtl/linear_seq_ctrl.sv
// linear_seq_ctrl: launches the Q, K and V linear passes strictly in order,
// grants the shared bar0 SRAM port to the active pass only, and reports one
// completion pulse, with a sticky error flag if a pass stalls in WAIT.
module linear_seq_ctrl #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        input_base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         pass_id,
  output logic [2:0]         lin_start,
  input  logic [2:0]         lin_done,
  input  logic [2:0]         lin_bar0_write_en,
  input  logic [3*WIDTH-1:0] lin_bar0_data_in,
  input  logic [3*32-1:0]    lin_bar0_addr,
  output logic [WIDTH-1:0]   lin_bar0_data_out,
  output logic               bar0_write_en,
  output logic [WIDTH-1:0]   bar0_data_in,
  output logic [31:0]        bar0_addr,
  input  logic [WIDTH-1:0]   bar0_data_out
);

  // The counter must be able to hold TIMEOUT itself, because the error fires
  // only once the counter has reached it without a done.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH,
    ERR
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      pass, pass_nx;
  logic [2:0]      grant, grant_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [31:0]     base, base_nx;
  logic            err_q, err_nx;
  logic            active_done;
  logic [31:0]     offset;

  function automatic logic [2:0] one_hot(input logic [1:0] p);
    one_hot = 3'b001 << p;
  endfunction

  // Only the active pass's done is honoured; the other bits are noise here.
  assign active_done = |(lin_done & one_hot(pass));

  // State and datapath registers; reset abandons any in-flight pass at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pass  <= 2'd0;
      grant <= 3'b000;
      cnt   <= '0;
      base  <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      pass  <= pass_nx;
      grant <= grant_nx;
      cnt   <= cnt_nx;
      base  <= base_nx;
      err_q <= err_nx;
    end
  end

  // Next-state logic; grant is loaded on the edge into LAUNCH so the new pass
  // owns bar0 from its launch cycle, and cleared on the edge out of WAIT.
  always_comb begin
    state_nx = state;
    pass_nx  = pass;
    grant_nx = grant;
    cnt_nx   = cnt;
    base_nx  = base;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          base_nx  = input_base;
          pass_nx  = 2'd0;
          err_nx   = 1'b0;
          grant_nx = one_hot(2'd0);
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (active_done) begin
          if (pass == 2'd2) begin
            grant_nx = 3'b000;
            state_nx = FINISH;
          end else begin
            pass_nx  = pass + 2'd1;
            grant_nx = one_hot(pass + 2'd1);
            state_nx = LAUNCH;
          end
        end else if (cnt == TMAX) begin
          err_nx   = 1'b1;
          grant_nx = 3'b000;
          state_nx = ERR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FINISH:  state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH) || (state == ERR);
  assign err       = err_q;
  assign pass_id   = busy ? pass : 2'd0;
  assign lin_start = (state == LAUNCH) ? one_hot(pass) : 3'b000;

  // bar0 mux driven purely from the registered grant so that non-granted
  // passes can never reach the SRAM write port.
  always_comb begin
    bar0_write_en = 1'b0;
    bar0_data_in  = '0;
    offset        = 32'd0;
    case (grant)
      3'b001: begin
        bar0_write_en = lin_bar0_write_en[0];
        bar0_data_in  = lin_bar0_data_in[0*WIDTH +: WIDTH];
        offset        = lin_bar0_addr[0*32 +: 32];
      end
      3'b010: begin
        bar0_write_en = lin_bar0_write_en[1];
        bar0_data_in  = lin_bar0_data_in[1*WIDTH +: WIDTH];
        offset        = lin_bar0_addr[1*32 +: 32];
      end
      3'b100: begin
        bar0_write_en = lin_bar0_write_en[2];
        bar0_data_in  = lin_bar0_data_in[2*WIDTH +: WIDTH];
        offset        = lin_bar0_addr[2*32 +: 32];
      end
      default: begin
        bar0_write_en = 1'b0;
      end
    endcase
  end

  // Address wraps silently modulo 2^32.
  assign bar0_addr         = base + offset;
  assign lin_bar0_data_out = bar0_data_out;

endmodule

// File: doc/linear_seq_ctrl.md
# linear_seq_ctrl

Sequencer that drives the three Q/K/V `linear` instances inside `mhsa_acc_top`, directly upstream of them. It accepts one accelerator `start` and launches the linear passes strictly in order Q, K, V, waiting for each pass's `done`. It time-multiplexes the shared input SRAM port (bar0) so only the active pass reaches it. It reports a single completion pulse, and flags an error if a pass hangs.

## Interface
- WIDTH, 64, SRAM data width
- TIMEOUT, 65535, max cycles a pass may spend in WAIT before error (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- input_base  in  32  bar0 base address, latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse (normal or error)
- err  out  1  sticky timeout flag
- pass_id  out  2  active pass: 0=Q, 1=K, 2=V; 0 when idle
- lin_start  out  3  one-hot launch pulse, bit i → pass i
- lin_done  in  3  done from pass i
- lin_bar0_write_en  in  3  per-pass bar0 write enable
- lin_bar0_data_in  in  3*WIDTH  per-pass write data, pass i at [i*WIDTH +: WIDTH]
- lin_bar0_addr  in  3*32  per-pass bar0 offset address, pass i at [i*32 +: 32]
- lin_bar0_data_out  out  WIDTH  bar0 read data, broadcast to all passes
- bar0_write_en  out  1  shared SRAM write enable
- bar0_data_in  out  WIDTH  shared SRAM write data
- bar0_addr  out  32  shared SRAM address
- bar0_data_out  in  WIDTH  shared SRAM read data

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH, ERR. Registers: state, pass counter (2 b), one-hot grant (3 b), timeout counter, latched base, err.
- IDLE: when start=1, latch input_base, pass:=0, clear err, go to LAUNCH. The error is cleared on the accepted start itself.
- LAUNCH (1 cycle):
  - lin_start[pass]=1.
  - grant:=one-hot(pass), effective this cycle.
  - Timeout counter:=0.
  - Go to WAIT.
- WAIT:
  - On lin_done[pass]=1: if pass==2, go to FINISH; otherwise pass++ and go to LAUNCH.
  - Else if counter==TIMEOUT, go to ERR.
  - Else counter++.
  - lin_done bits of non-active passes are ignored.
- FINISH (1 cycle): done=1, grant:=0, go to IDLE.
- ERR (1 cycle): done=1, err:=1 (held until next accepted start), grant:=0, go to IDLE.
- bar0 mux is combinational from the registered grant:
  - bar0_write_en = lin_bar0_write_en[g].
  - bar0_data_in = slice g of lin_bar0_data_in.
  - bar0_addr = latched base + slice g of lin_bar0_addr, modulo 2^32, wrap silently.
  - With grant=0: write_en=0, data_in=0, addr=latched base.
- Non-granted passes' write enables never reach bar0.
- lin_bar0_data_out = bar0_data_out, unconditionally (no added latency).
- start while busy is ignored, with no queueing.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, pass_id 0, lin_start 0, grant 0, bar0_write_en 0, bar0_data_in 0, bar0_addr 0 (latched base resets to 0).
- Launch latency: start sampled at edge 0 → lin_start[0] high in cycle 1.
- Pass-to-pass latency: lin_done[i] sampled at edge n → lin_start[i+1] high in cycle n+1.
- Completion: the final lin_done[2] at edge n → done high in cycle n+1 → busy low in cycle n+2. A new start is accepted from cycle n+2.
- Minimum total: done and timeout in WAIT 1 cycle each pass → done at cycle 7 after start.
- Simultaneous lin_done[pass] and counter==TIMEOUT: done wins, no error.
- lin_done[pass] high during LAUNCH is ignored; the linear raises done at least one cycle after its start.
- busy and done are registered from state. lin_start is decoded from state LAUNCH and is glitch-free.
- Reset mid-operation (rst_n low at any time): immediate return to the reset values above, in-flight pass abandoned, bar0 write enable drops asynchronously.

## Test plan
- Normal run: start pulse; each linear model asserts done 10 cycles after its start → lin_start bits 001, 010, 100 in cycles 1, 12, 23; done in cycle 34; err=0; pass_id tracks 0, 1, 2.
- Arbitration: all three models drive write_en=1 with distinct addr 0x10/0x20/0x30, input_base=0x1000 → during pass K, bar0_addr=0x1020 and only pass K's data appears; write_en=0 in IDLE and FINISH.
- Wrap: input_base=0xFFFF_FFF0, pass offset 0x20 → bar0_addr=0x0000_0010.
- Timeout: TIMEOUT=8, K model never asserts done → ERR reached, done pulse with err=1, lin_start[2] never asserted; next start clears err and a normal run completes.
- Noise and collisions: start re-pulsed mid-run and lin_done[2] pulsed during pass Q → both ignored, sequence unchanged; lin_done coincident with counter==TIMEOUT → no error.
- Reset mid-WAIT of pass K → all outputs at reset values next sample, bar0_write_en=0; a fresh start then runs from Q.
